// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for wb_bus_arbiter: the two packed Wishbone B3 master ports
// (master 1 in the upper half of every field) and the single slave port.
//
// Handshake: a master owns a transfer window while its cyc is high; each
// beat is offered while stb is high and completes on the cycle the slave
// answers with exactly one of ack/err/rty. Nothing else qualifies a beat.
//
// Modports:
//   slave  - the arbiter's view (it is the slave of both CPU masters and
//            the master of the memory bus)
//   master - the environment's view (CPU masters plus memory slave)
interface wb_bus_arbiter_if;
   logic [1:0]  m_cyc_i;
   logic [1:0]  m_stb_i;
   logic [1:0]  m_we_i;
   logic [63:0] m_adr_i;
   logic [7:0]  m_sel_i;
   logic [63:0] m_dat_i;
   logic [5:0]  m_cti_i;
   logic [3:0]  m_bte_i;
   logic [1:0]  m_ack_o;
   logic [1:0]  m_err_o;
   logic [1:0]  m_rty_o;
   logic [63:0] m_dat_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic [31:0] s_adr_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_dat_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o;
   logic        s_ack_i;
   logic        s_err_i;
   logic        s_rty_i;
   logic [31:0] s_dat_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
      output m_ack_o, m_err_o, m_rty_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
      input  s_ack_i, s_err_i, s_rty_i, s_dat_i
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
      input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
      output s_ack_i, s_err_i, s_rty_i, s_dat_i
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master to one-slave Wishbone B3 arbiter sharing the
// external memory bus between instruction fetch (master 0) and data
// (master 1). Round-robin on ties, bus locked for the owner's whole cyc
// window, and a no-response watchdog that errors out the stalled master.
//
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   bus        - wb_bus_arbiter_if.slave: packed master ports + slave port
//   grant_o    - one-hot current owner, 00 while idle
//   timeout_o  - one-cycle pulse when the watchdog fires
//   state_o    - FSM state for observation: 0 IDLE, 1 BUSY, 2 TOERR
//
// All slave-side signals are combinational from state/owner and the master
// inputs, so the arbiter adds no registered latency per beat.
module wb_bus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   wb_bus_arbiter_if.slave  bus,
   output logic [1:0]       grant_o,
   output logic             timeout_o,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      TOERR = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

   state_t          state, state_nxt;
   logic            owner, owner_nxt;
   logic            last, last_nxt;
   logic [TO_W-1:0] cnt, cnt_nxt;
   logic            resp;
   logic            own_cyc;
   logic            own_stb;
   logic [1:0]      own_hot;

   assign resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign own_cyc = owner ? bus.m_cyc_i[1] : bus.m_cyc_i[0];
   assign own_stb = owner ? bus.m_stb_i[1] : bus.m_stb_i[0];
   assign own_hot = owner ? 2'b10 : 2'b01;
   assign state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state. The counter defaults to clear, so only a stalled strobe in
   // BUSY keeps it counting; a response on the limit cycle wins over timeout.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (bus.m_cyc_i != 2'b00) begin
               case (bus.m_cyc_i)
                  2'b01:   owner_nxt = 1'b0;
                  2'b10:   owner_nxt = 1'b1;
                  default: owner_nxt = ~last;
               endcase
               last_nxt  = owner_nxt;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               state_nxt = IDLE;
            end else if (own_stb && !resp) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = TOERR;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         TOERR: begin
            // A master still holding cyc re-arbitrates from IDLE.
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_adr_o = '0;
      bus.s_sel_o = '0;
      bus.s_dat_o = '0;
      bus.s_cti_o = '0;
      bus.s_bte_o = '0;
      bus.m_ack_o = '0;
      bus.m_err_o = '0;
      bus.m_rty_o = '0;
      bus.m_dat_o = '0;
      grant_o     = '0;
      timeout_o   = 1'b0;
      case (state)
         BUSY: begin
            bus.s_cyc_o = own_cyc;
            bus.s_stb_o = own_stb;
            bus.s_we_o  = owner ? bus.m_we_i[1]       : bus.m_we_i[0];
            bus.s_adr_o = owner ? bus.m_adr_i[63:32]  : bus.m_adr_i[31:0];
            bus.s_sel_o = owner ? bus.m_sel_i[7:4]    : bus.m_sel_i[3:0];
            bus.s_dat_o = owner ? bus.m_dat_i[63:32]  : bus.m_dat_i[31:0];
            bus.s_cti_o = owner ? bus.m_cti_i[5:3]    : bus.m_cti_i[2:0];
            bus.s_bte_o = owner ? bus.m_bte_i[3:2]    : bus.m_bte_i[1:0];
            bus.m_ack_o = bus.s_ack_i ? own_hot : 2'b00;
            bus.m_err_o = bus.s_err_i ? own_hot : 2'b00;
            bus.m_rty_o = bus.s_rty_i ? own_hot : 2'b00;
            bus.m_dat_o = {bus.s_dat_i, bus.s_dat_i};
            grant_o     = own_hot;
         end
         TOERR: begin
            // Slave bus released; the stalled owner gets its error here.
            bus.m_err_o = own_hot;
            grant_o     = own_hot;
            timeout_o   = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios followed by a randomized
// phase, every cycle compared against a transaction-level reference model.
module tb_wb_bus_arbiter;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant_o;
   logic       timeout_o;
   logic [1:0] state_o;

   wb_bus_arbiter_if bus ();

   wb_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .grant_o   (grant_o),
      .timeout_o (timeout_o),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who holds the bus (-1 none), whether this cycle is the
   // timeout error cycle, who won the last grant, and how long the current
   // strobe has gone unanswered.
   int md_own;
   bit md_toerr;
   int md_last;
   int md_stall;

   function automatic logic [1:0] onehot(int o);
      return (o == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic all_off();
      bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
      bus.m_adr_i = '0; bus.m_sel_i = '0; bus.m_dat_i = '0;
      bus.m_cti_i = '0; bus.m_bte_i = '0;
      bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
      bus.s_dat_i = '0;
   endtask

   task automatic set_m(int i, bit cyc, bit stb, bit we, logic [31:0] adr, logic [2:0] cti);
      bus.m_cyc_i[i]        = cyc;
      bus.m_stb_i[i]        = stb;
      bus.m_we_i[i]         = we;
      bus.m_adr_i[32*i +: 32] = adr;
      bus.m_sel_i[4*i +: 4] = 4'hf;
      bus.m_dat_i[32*i +: 32] = adr ^ 32'h5a5a_0000;
      bus.m_cti_i[3*i +: 3] = cti;
      bus.m_bte_i[2*i +: 2] = 2'b00;
   endtask

   // Compare every output against the model at the falling edge, then move
   // the model across the coming rising edge.
   task automatic tick();
      logic [1:0]  g, ack, err, rty, st;
      logic        cyc, stb, we, to;
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic [1:0]  bte;
      logic [63:0] mdat;
      bit          resp;
      int          o;
      @(negedge clk);
      g = '0; ack = '0; err = '0; rty = '0; st = 2'd0;
      cyc = 0; stb = 0; we = 0; to = 0;
      adr = '0; dat = '0; sel = '0; cti = '0; bte = '0; mdat = '0;
      if (md_toerr) begin
         g = onehot(md_own); err = g; to = 1'b1; st = 2'd2;
      end else if (md_own >= 0) begin
         o    = md_own;
         g    = onehot(o);
         cyc  = bus.m_cyc_i[o];
         stb  = bus.m_stb_i[o];
         we   = bus.m_we_i[o];
         adr  = 32'(bus.m_adr_i >> (32 * o));
         dat  = 32'(bus.m_dat_i >> (32 * o));
         sel  = 4'(bus.m_sel_i >> (4 * o));
         cti  = 3'(bus.m_cti_i >> (3 * o));
         bte  = 2'(bus.m_bte_i >> (2 * o));
         ack  = bus.s_ack_i ? g : 2'b00;
         err  = bus.s_err_i ? g : 2'b00;
         rty  = bus.s_rty_i ? g : 2'b00;
         mdat = {bus.s_dat_i, bus.s_dat_i};
         st   = 2'd1;
      end
      chk("grant", 64'(grant_o), 64'(g));
      chk("slave_ctl", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'({cyc, stb, we}));
      chk("slave_fields", 64'({bus.s_adr_o, bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}),
          64'({adr, sel, cti, bte}));
      chk("slave_wdat", 64'(bus.s_dat_o), 64'(dat));
      chk("master_resp", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 64'({ack, err, rty}));
      chk("master_rdat", bus.m_dat_o, mdat);
      chk("timeout", 64'(timeout_o), 64'(to));
      chk("state", 64'(state_o), 64'(st));

      resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
      if (rst) begin
         md_own = -1; md_toerr = 0; md_last = 1; md_stall = 0;
      end else if (md_toerr) begin
         md_toerr = 0; md_own = -1; md_stall = 0;
      end else if (md_own < 0) begin
         if (bus.m_cyc_i == 2'b01) md_own = 0;
         else if (bus.m_cyc_i == 2'b10) md_own = 1;
         else if (bus.m_cyc_i == 2'b11) md_own = 1 - md_last;
         if (md_own >= 0) md_last = md_own;
         md_stall = 0;
      end else if (!bus.m_cyc_i[md_own]) begin
         md_own = -1; md_stall = 0;
      end else if (bus.m_stb_i[md_own] && !resp) begin
         md_stall++;
         if (md_stall == TIMEOUT) begin
            md_toerr = 1; md_stall = 0;
         end
      end else begin
         md_stall = 0;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      tick();
      adv();
   endtask

   initial begin
      bit silent;
      int r;
      all_off();
      rst = 1'b1;
      md_own = -1; md_toerr = 0; md_last = 1; md_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state: all outputs low
      tick();
      chk("reset_grant", 64'(grant_o), 64'(2'b00));
      chk("reset_scyc", 64'(bus.s_cyc_o), 64'(1'b0));
      adv();

      // 1: master 0 single read of 0x100, ack after two wait cycles
      set_m(0, 1, 1, 0, 32'h100, 3'b000);
      tick(); chk("t1_lat_idle", 64'(bus.s_cyc_o), 64'(1'b0)); adv();
      tick(); chk("t1_scyc", 64'(bus.s_cyc_o), 64'(1'b1));
      chk("t1_adr", 64'(bus.s_adr_o), 64'(32'h100)); adv();
      step();
      bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hcafe_0001;
      tick(); chk("t1_ack", 64'(bus.m_ack_o), 64'(2'b01)); adv();
      all_off();
      tick(); chk("t1_grant_hold", 64'(grant_o), 64'(2'b01)); adv();
      tick(); chk("t1_grant_rel", 64'(grant_o), 64'(2'b00)); adv();

      // 2: tie after reset goes to master 0, then master 1, then master 0
      rst = 1'b1; step(); rst = 1'b0;
      set_m(0, 1, 1, 0, 32'h10, 3'b000);
      set_m(1, 1, 1, 1, 32'h20, 3'b000);
      step();
      tick(); chk("t2_first", 64'(grant_o), 64'(2'b01)); adv();
      bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
      step();
      tick(); chk("t2_gap", 64'(bus.s_cyc_o), 64'(1'b0)); adv();
      tick(); chk("t2_second", 64'(grant_o), 64'(2'b10)); adv();
      bus.m_cyc_i = 2'b00; step();
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; step();
      tick(); chk("t2_third", 64'(grant_o), 64'(2'b01)); adv();
      all_off(); step(); step();

      // 3: master 1 4-beat incrementing burst locks out master 0
      set_m(1, 1, 1, 0, 32'h200, 3'b010);
      step();
      set_m(0, 1, 1, 0, 32'h300, 3'b000);
      for (int b = 0; b < 4; b++) begin
         set_m(1, 1, 1, 0, 32'h200 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
         bus.s_ack_i = 1'b1; bus.s_dat_i = $urandom;
         tick();
         chk("t3_grant", 64'(grant_o), 64'(2'b10));
         chk("t3_ack", 64'(bus.m_ack_o), 64'(2'b10));
         adv();
      end
      bus.s_ack_i = 1'b0; bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0;
      step();
      step();
      tick(); chk("t3_m0_after", 64'(grant_o), 64'(2'b01)); adv();
      all_off(); step(); step();

      // 4: silent slave on a master 1 write -> TOERR after 8 stb cycles
      set_m(1, 1, 1, 1, 32'h400, 3'b000);
      step();
      for (int k = 0; k < TIMEOUT; k++) step();
      tick();
      chk("t4_err", 64'(bus.m_err_o), 64'(2'b10));
      chk("t4_pulse", 64'(timeout_o), 64'(1'b1));
      chk("t4_scyc", 64'(bus.s_cyc_o), 64'(1'b0));
      adv();
      all_off();
      tick(); chk("t4_idle", 64'(state_o), 64'(2'd0)); adv();

      // 5: ack on the 8th stb cycle beats the watchdog
      set_m(1, 1, 1, 1, 32'h500, 3'b000);
      step();
      for (int k = 0; k < TIMEOUT - 1; k++) step();
      bus.s_ack_i = 1'b1;
      tick();
      chk("t5_ack", 64'(bus.m_ack_o), 64'(2'b10));
      chk("t5_no_to", 64'(timeout_o), 64'(1'b0));
      adv();
      all_off();
      tick(); chk("t5_no_to_next", 64'(timeout_o), 64'(1'b0)); adv();
      step();

      // 6: reset during the third burst beat, then a tie goes to master 0
      set_m(1, 1, 1, 0, 32'h600, 3'b010);
      step();
      bus.s_ack_i = 1'b1;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      bus.s_ack_i = 1'b0;
      set_m(0, 1, 1, 0, 32'h700, 3'b000);
      tick();
      chk("t6_state", 64'(state_o), 64'(2'd0));
      chk("t6_scyc", 64'(bus.s_cyc_o), 64'(1'b0));
      chk("t6_err", 64'(bus.m_err_o), 64'(2'b00));
      adv();
      tick(); chk("t6_tie", 64'(grant_o), 64'(2'b01)); adv();
      all_off(); step(); step();

      // Randomized traffic, with silent-slave stretches to reach the watchdog
      silent = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) silent = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 99) < (silent ? 4 : 12)) bus.m_cyc_i[i] = ~bus.m_cyc_i[i];
            bus.m_stb_i[i] = bus.m_cyc_i[i] & ($urandom_range(0, 99) < (silent ? 95 : 75));
            bus.m_we_i[i]  = 1'($urandom_range(0, 1));
            bus.m_sel_i[4*i +: 4] = 4'($urandom_range(0, 15));
            bus.m_cti_i[3*i +: 3] = 3'($urandom_range(0, 7));
            bus.m_bte_i[2*i +: 2] = 2'($urandom_range(0, 3));
         end
         bus.m_adr_i = {$urandom, $urandom};
         bus.m_dat_i = {$urandom, $urandom};
         r = $urandom_range(0, 99);
         bus.s_ack_i = !silent && (r < 30);
         bus.s_err_i = !silent && (r >= 30) && (r < 34);
         bus.s_rty_i = !silent && (r >= 34) && (r < 38);
         bus.s_dat_i = $urandom;
         rst = ($urandom_range(0, 599) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
Two-master to one-slave Wishbone B3 arbiter. It shares the single external memory bus between the instruction-fetch master (port 0) and the data master (port 1) of fet_dec_ex_mem. Master-side buses are packed exactly as the CPU top exports them: per-master fields are concatenated, with master 1 in the upper half. The block adds round-robin grant, bus locking for the full cyc window, and a no-response watchdog that returns an error to the stalled master.

Parameters:
TIMEOUT, 255, number of stb-asserted cycles without ack/err/rty before the watchdog fires (legal range 2..2^TO_W-1)
TO_W, 8, width of the watchdog counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
m_cyc_i  input  2  per-master cyc; bit i = master i
m_stb_i  input  2  per-master stb
m_we_i  input  2  per-master we
m_adr_i  input  64  master i address in [32i+31:32i]
m_sel_i  input  8  master i byte selects in [4i+3:4i]
m_dat_i  input  64  master i write data in [32i+31:32i]
m_cti_i  input  6  master i cti in [3i+2:3i]
m_bte_i  input  4  master i bte in [2i+1:2i]
m_ack_o  output  2  ack routed to the owner only
m_err_o  output  2  err routed to the owner, or watchdog error
m_rty_o  output  2  rty routed to the owner only
m_dat_o  output  64  s_dat_i replicated into both halves
s_cyc_o, s_stb_o, s_we_o  output  1 each  slave control
s_adr_o  output  32  slave address
s_sel_o  output  4  slave byte selects
s_dat_o  output  32  slave write data
s_cti_o  output  3  slave cti
s_bte_o  output  2  slave bte
s_ack_i, s_err_i, s_rty_i  input  1 each  slave response
s_dat_i  input  32  slave read data
grant_o  output  2  one-hot current owner; 00 when the bus is idle
timeout_o  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Registered state: `state` ∈ {IDLE, BUSY, TOERR}, `owner` (1 bit), `last` (1 bit), `cnt` (TO_W bits).
- Reset values: state=IDLE, owner=0, last=1, cnt=0. All outputs are 0 while in IDLE, including grant_o and timeout_o.
- IDLE transitions:
  - No m_cyc_i bit set → stay in IDLE.
  - Exactly one m_cyc_i bit set → owner=that master, go to BUSY.
  - Both bits set → owner=~last, go to BUSY.
  - On entering BUSY, last is loaded with the new owner.
- Grant latency: cyc sampled high in IDLE at edge n → s_cyc_o=1 from cycle n+1.
- There is always at least one IDLE cycle (s_cyc_o=0) between consecutive grants.
- BUSY outputs (combinational from owner):
  - s_cyc_o = m_cyc_i[owner]; stb, we, adr, sel, dat, cti and bte are taken from the owner's slice.
  - grant_o[owner]=1.
  - m_ack_o[owner]=s_ack_i, m_err_o[owner]=s_err_i, m_rty_o[owner]=s_rty_i.
  - The non-owner always sees 0 on ack, err and rty.
- The bus is locked: requests from the non-owner are ignored while in BUSY. Bursts (cti 001/010) run uninterrupted to end of cyc.
- BUSY → IDLE when m_cyc_i[owner]=0. A response and the cyc drop in the same cycle are legal; the response is still routed to the owner.
- Slave err and rty pass through to the owner; the arbiter stays in BUSY until the owner drops cyc.
- Watchdog counter (cnt):
  - In BUSY with s_stb_o=1 and no ack/err/rty: cnt increments.
  - On any response, on stb low, or outside BUSY: cnt is cleared.
  - When cnt==TIMEOUT-1 and no response arrives this cycle, at the next edge: state=TOERR, cnt=0.
- TOERR (exactly one cycle):
  - s_cyc_o=s_stb_o=0.
  - m_err_o[owner]=1, timeout_o=1, grant_o is held.
  - Next state is IDLE unconditionally. If the owner still holds cyc, it re-arbitrates as a new request.
- A response arriving on the same cycle the count reaches the limit wins: no timeout fires.
- Synchronous reset asserted mid-transfer: at the next edge the block returns to IDLE and the slave bus is released. Any transfer in flight is abandoned and no err is generated.
- s_cyc_o, s_stb_o and all slave fields are combinational on state/owner and master inputs, so the arbiter adds no registered latency per beat.

Test Plan:
1. Master 0 alone issues a single read to adr 0x100 and the slave acks after 2 cycles → s_cyc_o rises 1 cycle after m_cyc_i[0], s_adr_o=0x100, m_ack_o=01 for one cycle, grant_o returns to 00 one cycle after cyc drops.
2. Both masters raise cyc in the same cycle right after reset → master 0 is granted first (last=1). After master 0 drops cyc there is one idle cycle, then grant_o=10. A second tie then goes to master 0.
3. Master 1 runs a 4-beat incrementing burst (cti 010→111) while master 0 requests → grant_o stays 10 for all 4 acks, m_ack_o[0] stays 0, and master 0 is granted afterwards.
4. TIMEOUT=8, slave never responds to a master 1 write → after 8 stb cycles: a TOERR cycle with m_err_o=10, timeout_o=1, s_cyc_o=0, then IDLE.
5. TIMEOUT=8, ack arrives on the 8th stb cycle → normal ack, timeout_o stays 0.
6. rst pulsed for one cycle during the third beat of a burst → next cycle all outputs are 0 and state is IDLE. The next tie grants master 0.
